// File: rtl/piso_bit_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_bit_feeder : WIDTH-bit valid/ready word to gap-free serial bit stream  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   C_LAST   = CW'(WIDTH - 1);
  localparam logic [0:0]      C_IDLE   = 1'b0;
  localparam logic [0:0]      C_SHIFT  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;

  logic [WIDTH-1:0] w_load_sh;
  logic [WIDTH-1:0] w_shift_sh;
  logic             w_load_bit;
  logic             w_shift_bit;
  logic             w_accept;

  // sh_q holds only the bits not yet presented; the bit on x has already left it
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_load_bit  = din[WIDTH-1];
      assign w_load_sh   = {din[WIDTH-2:0], 1'b0};
      assign w_shift_bit = sh_q[WIDTH-1];
      assign w_shift_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_bit  = din[0];
      assign w_load_sh   = {1'b0, din[WIDTH-1:1]};
      assign w_shift_bit = sh_q[0];
      assign w_shift_sh  = {1'b0, sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
    end
  end

  assign w_accept = din_valid & din_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    if (w_accept) begin
      state_d = C_SHIFT;
      cnt_d   = '0;
      sh_d    = w_load_sh;
      x_d     = w_load_bit;
      xv_d    = 1'b1;
    end else if ((state_q == C_SHIFT) && !last) begin
      cnt_d   = cnt_q + CW'(1);
      sh_d    = w_shift_sh;
      x_d     = w_shift_bit;
      xv_d    = 1'b1;
    end else begin
      state_d = C_IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end
  end

  // Ready depends on state only, so a source may compute din_valid from it freely
  always_comb begin
    last      = (state_q == C_SHIFT) && (cnt_q == C_LAST);
    din_ready = (state_q == C_IDLE) || last;
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign busy    = xv_q;

endmodule
`default_nettype wire
